// File: rtl/pipeline_stall_ctrl_if.sv
// Stall-controller bus: hazard/wait requests from the pipeline and the stall vector returned to it.
// master = pipeline side, slave = stall controller.
interface pipeline_stall_ctrl_if;
  logic        id_stallreq;
  logic        ex_mc_start;
  logic        mem_req;
  logic        mem_ready;
  logic [5:0]  stall;
  logic        ex_mc_done;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output id_stallreq, ex_mc_start, mem_req, mem_ready,
    input  stall, ex_mc_done, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_stallreq, ex_mc_start, mem_req, mem_ready,
    output stall, ex_mc_done, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall controller: merges MEM wait (with timeout), multi-cycle EX hold and ID load-use
// requests into the 6-bit stall vector, and counts cycles in which the PC is stalled.
module pipeline_stall_ctrl #(
  parameter int unsigned MC_CYCLES   = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  pipeline_stall_ctrl_if.slave       bus
);

  localparam logic [7:0] MC_LOAD    = 8'(MC_CYCLES - 2);
  localparam logic [7:0] TIMEOUT_W  = 8'(MEM_TIMEOUT);

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  mc_state_t   state_reg, state_next;
  logic [7:0]  mc_cnt_reg, mc_cnt_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        mem_timeout_reg;
  logic [31:0] stall_cycles_reg;

  logic        mem_stall;
  logic        timeout_hit;
  logic        ex_req;
  logic        mc_done;
  logic [5:0]  stall_vec;

  always_comb begin
    mem_stall     = 1'b0;
    timeout_hit   = 1'b0;
    wait_cnt_next = 8'd0;
    if (bus.mem_req && !bus.mem_ready) begin
      if (wait_cnt_reg < TIMEOUT_W) begin
        mem_stall     = 1'b1;
        wait_cnt_next = wait_cnt_reg + 8'd1;
      end else begin
        timeout_hit   = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    mc_cnt_next = mc_cnt_reg;
    ex_req      = 1'b0;
    mc_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.ex_mc_start) begin
          ex_req      = 1'b1;
          mc_cnt_next = MC_LOAD;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        ex_req = 1'b1;
        if (mc_cnt_reg == 8'd0) begin
          state_next = DONE;
        end else begin
          mc_cnt_next = mc_cnt_reg - 8'd1;
        end
      end
      DONE: begin
        mc_done = 1'b1;
        // With no EX request in DONE, stall[3] can only come from a MEM wait.
        if (!mem_stall) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    stall_vec = 6'b000000;
    if (reset) begin
      stall_vec = 6'b000000;
    end else if (mem_stall) begin
      stall_vec = STALL_MEM;
    end else if (ex_req) begin
      stall_vec = STALL_EX;
    end else if (bus.id_stallreq) begin
      stall_vec = STALL_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      mc_cnt_reg       <= 8'd0;
      wait_cnt_reg     <= 8'd0;
      mem_timeout_reg  <= 1'b0;
      stall_cycles_reg <= 32'd0;
    end else begin
      state_reg        <= state_next;
      mc_cnt_reg       <= mc_cnt_next;
      wait_cnt_reg     <= wait_cnt_next;
      mem_timeout_reg  <= mem_timeout_reg | timeout_hit;
      if (stall_vec[0]) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
    end
  end

  assign bus.stall        = stall_vec;
  assign bus.ex_mc_done   = mc_done && !reset;
  assign bus.mem_timeout  = mem_timeout_reg;
  assign bus.stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed, table-driven bench for pipeline_stall_ctrl (MC_CYCLES=4, MEM_TIMEOUT=16).
module tb_pipeline_stall_ctrl;

  logic clk;
  logic reset;

  pipeline_stall_ctrl_if bus ();

  pipeline_stall_ctrl #(
    .MC_CYCLES   (4),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        id;
    logic        mc;
    logic        mreq;
    logic        mrdy;
    logic [5:0]  exp_stall;
    logic        exp_done;
    logic        exp_to;
    logic [31:0] exp_cyc;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  vec_t tbl [26];

  function automatic vec_t mk(input logic rst, input logic id, input logic mc,
                              input logic mreq, input logic mrdy, input logic [5:0] st,
                              input logic done, input logic to, input int cyc);
    vec_t v;
    v.rst = rst; v.id = id; v.mc = mc; v.mreq = mreq; v.mrdy = mrdy;
    v.exp_stall = st; v.exp_done = done; v.exp_to = to; v.exp_cyc = 32'(cyc);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check settled outputs mid-cycle, then advance past the edge.
  task automatic apply(input vec_t v, input string tag);
    reset           = v.rst;
    bus.id_stallreq = v.id;
    bus.ex_mc_start = v.mc;
    bus.mem_req     = v.mreq;
    bus.mem_ready   = v.mrdy;
    #1;
    check({tag, " stall"},        32'(bus.stall),       32'(v.exp_stall));
    check({tag, " ex_mc_done"},   32'(bus.ex_mc_done),  32'(v.exp_done));
    check({tag, " mem_timeout"},  32'(bus.mem_timeout), 32'(v.exp_to));
    check({tag, " stall_cycles"}, bus.stall_cycles,     v.exp_cyc);
    $display("%s: in rst=%0b id=%0b mc=%0b req=%0b rdy=%0b -> stall=%06b done=%0b to=%0b cyc=%0d",
             tag, v.rst, v.id, v.mc, v.mreq, v.mrdy, bus.stall, bus.ex_mc_done,
             bus.mem_timeout, bus.stall_cycles);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                 rst id mc req rdy  stall      done to  cyc
    tbl[0]  = mk(1, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 6'b000111, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
    tbl[4]  = mk(0, 0, 1, 0, 0, 6'b001111, 0, 0, 1);
    tbl[5]  = mk(0, 0, 1, 0, 0, 6'b001111, 0, 0, 2);
    tbl[6]  = mk(0, 0, 1, 0, 0, 6'b001111, 0, 0, 3);
    tbl[7]  = mk(0, 0, 1, 0, 0, 6'b001111, 0, 0, 4);
    tbl[8]  = mk(0, 0, 1, 0, 0, 6'b000000, 1, 0, 5);
    tbl[9]  = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 5);
    tbl[10] = mk(0, 0, 0, 1, 0, 6'b011111, 0, 0, 5);
    tbl[11] = mk(0, 0, 0, 1, 0, 6'b011111, 0, 0, 6);
    tbl[12] = mk(0, 0, 0, 1, 0, 6'b011111, 0, 0, 7);
    tbl[13] = mk(0, 0, 0, 1, 1, 6'b000000, 0, 0, 8);
    tbl[14] = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 8);
    tbl[15] = mk(0, 0, 0, 1, 1, 6'b000000, 0, 0, 8);
    tbl[16] = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 8);
    tbl[17] = mk(0, 1, 0, 1, 0, 6'b011111, 0, 0, 8);
    tbl[18] = mk(0, 1, 0, 0, 0, 6'b000111, 0, 0, 9);
    tbl[19] = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 10);
    tbl[20] = mk(0, 1, 1, 0, 0, 6'b001111, 0, 0, 10);
    tbl[21] = mk(0, 1, 1, 0, 0, 6'b001111, 0, 0, 11);
    tbl[22] = mk(0, 1, 1, 0, 0, 6'b001111, 0, 0, 12);
    tbl[23] = mk(0, 1, 1, 0, 0, 6'b001111, 0, 0, 13);
    tbl[24] = mk(0, 1, 1, 0, 0, 6'b000111, 1, 0, 14);
    tbl[25] = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 15);

    reset           = 1'b1;
    bus.id_stallreq = 1'b0;
    bus.ex_mc_start = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_ready   = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Memory wait with no ready: 16 stall cycles, release on the 17th, sticky timeout.
    for (int k = 0; k < 16; k++) begin
      apply(mk(0, 0, 0, 1, 0, 6'b011111, 0, 0, 15 + k), $sformatf("tmo_wait%0d", k));
    end
    apply(mk(0, 0, 0, 1, 0, 6'b000000, 0, 0, 31), "tmo_release");
    for (int k = 0; k < 3; k++) begin
      apply(mk(0, 0, 0, 0, 0, 6'b000000, 0, 1, 31), $sformatf("tmo_sticky%0d", k));
    end

    reset = 1'b1;
    bus.mem_req = 1'b0;
    @(posedge clk);
    #1;

    // Multi-cycle op overlapped by a MEM wait: DONE is held until stall[3] drops.
    apply(mk(0, 0, 1, 0, 0, 6'b001111, 0, 0, 0), "mix0");
    apply(mk(0, 0, 1, 0, 0, 6'b001111, 0, 0, 1), "mix1");
    apply(mk(0, 0, 1, 1, 0, 6'b011111, 0, 0, 2), "mix2");
    apply(mk(0, 0, 1, 1, 0, 6'b011111, 0, 0, 3), "mix3");
    apply(mk(0, 0, 1, 1, 0, 6'b011111, 1, 0, 4), "mix4");
    apply(mk(0, 0, 1, 1, 0, 6'b011111, 1, 0, 5), "mix5");
    apply(mk(0, 0, 1, 0, 0, 6'b000000, 1, 0, 6), "mix6");
    apply(mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 6), "mix7");

    // Reset in the middle of BUSY aborts the op without a done pulse.
    apply(mk(0, 0, 1, 0, 0, 6'b001111, 0, 0, 6), "rbusy0");
    apply(mk(0, 0, 1, 0, 0, 6'b001111, 0, 0, 7), "rbusy1");
    apply(mk(1, 0, 0, 0, 0, 6'b000000, 0, 0, 8), "rbusy_rst");
    apply(mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0), "rbusy_after0");
    apply(mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0), "rbusy_after1");
    apply(mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0), "rbusy_after2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall controller for the five-stage pipeline: it produces the 6-bit `stall` vector consumed by the PC and by every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB). It merges three stall sources in priority order:

- the ID load-use hazard request;
- an internal FSM that holds EX for a fixed number of cycles during multi-cycle ALU operations (divide);
- a data-memory wait handshake with timeout.

It also keeps a free-running stall-cycle performance counter.

## Interface
Parameters:
- `MC_CYCLES`, 4: cycles EX is held for a multi-cycle op; legal range 2..255.
- `MEM_TIMEOUT`, 16: maximum consecutive MEM wait-stall cycles; legal range 1..255.

Ports:
- `clk`  input  1  — single clock; all state updates on posedge.
- `reset`  input  1  — synchronous, active-high.
- `id_stallreq`  input  1  — load-use hazard detected in ID (combinational, same cycle).
- `ex_mc_start`  input  1  — instruction in EX is a multi-cycle op; held high while it sits in EX.
- `mem_req`  input  1  — MEM stage has an outstanding data-memory access.
- `mem_ready`  input  1  — data memory completes the access this cycle.
- `stall`  output  6  — bit i holds stage i: 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB (reserved, always 0).
- `ex_mc_done`  output  1  — multi-cycle result valid in EX this cycle.
- `mem_timeout`  output  1  — sticky: a memory wait exceeded `MEM_TIMEOUT`.
- `stall_cycles`  output  32  — count of cycles with `stall[0]`=1.

## Operation
- `stall` is combinational from FSM state, wait counter and inputs. Priority is MEM > EX > ID:
  - MEM request: `stall`=6'b011111.
  - EX request: `stall`=6'b001111.
  - ID request: `stall`=6'b000111.
  - otherwise: 6'b000000.
- Pattern semantics: the downstream register of the highest held stage inserts a bubble, per the stall[i]=1 && stall[i+1]=0 rule.
- Multi-cycle FSM, states IDLE, BUSY, DONE; 8-bit counter `mc_cnt`:
  - IDLE: if `ex_mc_start`=1, request EX stall this cycle, load `mc_cnt`=MC_CYCLES-2, go to BUSY.
  - BUSY: request EX stall. If `mc_cnt`=0 go to DONE, else decrement. Counting continues regardless of MEM stalls.
  - DONE: no EX request; `ex_mc_done`=1; `ex_mc_start` ignored. Stay in DONE while `stall[3]`=1 (MEM stall holding EX). Go to IDLE on the first cycle with `stall[3]`=0.
- Memory wait, 8-bit `wait_cnt`:
  - MEM request = `mem_req` && !`mem_ready` && `wait_cnt` < MEM_TIMEOUT.
  - `wait_cnt` increments each cycle the MEM request is active.
  - It clears to 0 when `mem_ready`=1, when `mem_req`=0, or in the cycle `wait_cnt`=MEM_TIMEOUT.
  - In that timeout cycle, stall is released and `mem_timeout` is set at the next edge. It remains set until reset.
- `stall_cycles` increments at each edge where `stall[0]`=1 and wraps 0xFFFFFFFF→0.

## Timing
- Reset values:
  - `stall`=0, `ex_mc_done`=0, `mem_timeout`=0, `stall_cycles`=0.
  - FSM=IDLE, `mc_cnt`=0, `wait_cnt`=0.
- Reset wins over every other event in the same cycle. Reset mid-BUSY aborts the op: FSM returns to IDLE and no `ex_mc_done` is issued.
- Zero-cycle latency from request inputs to `stall`.
- Multi-cycle op with no other stalls:
  - EX stalled for exactly MC_CYCLES cycles (1 IDLE + MC_CYCLES-1 BUSY).
  - Then 1 DONE cycle in which EX/MEM captures the result.
  - Total MC_CYCLES+1 cycles in EX.
- ID request concurrent with BUSY is masked by the EX pattern. It reappears after release if still asserted.
- A memory access waits at most MEM_TIMEOUT stall cycles. Stall is released in cycle MEM_TIMEOUT+1 of the wait.
- `mem_ready`=1 in the first cycle of `mem_req` causes no stall.

## Test plan
- Reset held 2 cycles, all inputs 0 -> `stall`=0, `stall_cycles`=0, `mem_timeout`=0, `ex_mc_done`=0. Check both during reset and the cycle after.
- `id_stallreq`=1 for 1 cycle -> `stall`=6'b000111 that cycle only; `stall_cycles`=1 afterwards.
- MC_CYCLES=4, `ex_mc_start` held until the DONE cycle has passed -> `stall`=6'b001111 for 4 consecutive cycles, then `stall`=0 with `ex_mc_done`=1 for 1 cycle, then IDLE; `stall_cycles`=4.
- `mem_req`=1, `mem_ready` rises on 4th cycle -> `stall`=6'b011111 for 3 cycles, 0 on 4th; `mem_timeout` stays 0.
- MEM_TIMEOUT=16, `mem_req`=1, `mem_ready`=0 held -> 16 stall cycles, released on 17th; `mem_timeout`=1 from next edge and persists after `mem_req` drops until reset.
- MC_CYCLES=4 op started; `mem_req`=1 without ready over BUSY cycles 3-6 -> `stall`=6'b011111 during the wait. The FSM reaches DONE during the wait and holds DONE with `ex_mc_done`=1 until `stall[3]`=0. It then returns to IDLE.
